// File: rtl/iq_pkg.sv
// Shared types and constants for the instruction queue and its ring buffer.
package iq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    localparam int IQ_PC_STEP       = 4;
    localparam int IQ_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/iq_ring_buffer.sv
// Circular storage of tagged entries with read/write pointers and an explicit
// occupancy counter. The caller guarantees wr_en only when not full and rd_en only when not empty.
module iq_ring_buffer
    import iq_pkg::*;
#(
    parameter int DEPTH = IQ_DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      wr_en,
    input  iq_entry_t wr_data,
    input  logic      rd_en,
    output iq_entry_t rd_data,
    output logic [AW:0] count,
    output logic      full,
    output logic      empty
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    iq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointers are exactly AW bits, so DEPTH-1 -> 0 wraps by overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !clr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction buffer with PC tagging, flush/redirect and sticky overflow.
// Optional same-cycle bypass to decode when empty is enabled by defining IQ_BYPASS_EN.
module instruction_queue
    import iq_pkg::*;
#(
    parameter int          DEPTH    = IQ_DEFAULT_DEPTH,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      iq_valid,
    input  logic [31:0]               instruction,
    output logic                      enq_ready,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [31:0]               deq_instr,
    output logic [31:0]               deq_pc,
    input  logic                      flush,
    input  logic [31:0]               redirect_pc,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    // Handshakes: upstream iq_valid is a strobe with no back-pressure (enq_ready
    // is advisory; a word offered while full is lost). Downstream pops the head on
    // any cycle where deq_valid && deq_ready, and flush cancels both sides.

    logic [31:0] next_pc;
    iq_entry_t   head;
    logic        buf_full;
    logic        buf_empty;
    logic        enq_fire;
    logic        store;
    logic        pop;
    logic        bypass_hit;
    logic        bypass_take;

    always_comb begin
        enq_fire = iq_valid && !buf_full && !flush;
        pop      = !buf_empty && deq_ready && !flush;
`ifdef IQ_BYPASS_EN
        bypass_hit  = buf_empty && iq_valid && !flush;
        bypass_take = bypass_hit && deq_ready;
`else
        bypass_hit  = 1'b0;
        bypass_take = 1'b0;
`endif
        // A bypassed word that is consumed immediately never touches storage.
        store = enq_fire && !bypass_take;
    end

    iq_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk_in),
        .rst     (rst_in),
        .clr     (flush),
        .wr_en   (store),
        .wr_data ('{pc: next_pc, instr: instruction}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            next_pc  <= PC_RESET;
            overflow <= 1'b0;
        end else if (flush) begin
            next_pc <= redirect_pc;
        end else begin
            if (enq_fire) next_pc <= next_pc + 32'(IQ_PC_STEP);
            if (iq_valid && buf_full) overflow <= 1'b1;
        end
    end

    always_comb begin
        deq_valid = !buf_empty || bypass_hit;
        deq_instr = 32'h0;
        deq_pc    = 32'h0;
        if (!buf_empty) begin
            deq_instr = head.instr;
            deq_pc    = head.pc;
        end else if (bypass_hit) begin
            deq_instr = instruction;
            deq_pc    = next_pc;
        end
    end

    assign enq_ready = !buf_full;
    assign full      = buf_full;
    assign empty     = buf_empty;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_instruction_queue;
    import iq_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          iq_valid;
    logic [31:0]   instruction;
    logic          enq_ready;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_instr;
    logic [31:0]   deq_pc;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    instruction_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .iq_valid    (iq_valid),
        .instruction (instruction),
        .enq_ready   (enq_ready),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_instr   (deq_instr),
        .deq_pc      (deq_pc),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [63:0] exp_q[$];
    logic [31:0] m_pc  = 32'h0;
    logic        m_ovf = 1'b0;
    bit          m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        int          n;
        n       = exp_q.size();
        e_valid = 1'b0;
        e_instr = 32'h0;
        e_pc    = 32'h0;
        if (n > 0) begin
            e_valid = 1'b1;
            e_pc    = exp_q[0][63:32];
            e_instr = exp_q[0][31:0];
        end else if (BYP && iq_valid && !flush) begin
            e_valid = 1'b1;
            e_pc    = m_pc;
            e_instr = instruction;
        end
        chk("m_deq_valid", 32'(deq_valid), 32'(e_valid));
        chk("m_deq_instr", deq_instr, e_instr);
        chk("m_deq_pc", deq_pc, e_pc);
        chk("m_count", 32'(count), 32'(n));
        chk("m_full", 32'(full), 32'(n == DEPTH));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_enq_ready", 32'(enq_ready), 32'(n != DEPTH));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge: drive, check on the falling edge, advance model, step.
    task automatic cycle(input logic r, input logic iv, input logic [31:0] ins,
                         input logic dr, input logic fl, input logic [31:0] rpc);
        int n;
        bit take;
        rst_in = r; iq_valid = iv; instruction = ins;
        deq_ready = dr; flush = fl; redirect_pc = rpc;
        @(negedge clk_in);
        if (m_live && !r) check_model();
        if (r) begin
            exp_q.delete();
            m_pc   = 32'h0;
            m_ovf  = 1'b0;
            m_live = 1'b1;
        end else if (fl) begin
            exp_q.delete();
            m_pc = rpc;
        end else begin
            n    = exp_q.size();
            take = BYP && (n == 0) && iv && dr;
            if (n > 0 && dr) void'(exp_q.pop_front());
            if (iv && n < DEPTH) begin
                if (!take) exp_q.push_back({m_pc, ins});
                m_pc = m_pc + 32'd4;
            end
            if (iv && n == DEPTH) m_ovf = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; iq_valid = 1'b0; instruction = 32'h0;
        deq_ready = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        dr;
        logic        fl;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        int          e_count;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 32'h00158593, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00158593, 32'h0,        1};
        vecs[1]  = '{1'b1, 32'h00260613, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00158593, 32'h0,        2};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h00260613, 32'h4,        1};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        0};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        0};
        vecs[5]  = '{1'b1, 32'h00368693, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00368693, 32'h8,        1};
        vecs[6]  = '{1'b1, 32'h0badf00d, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        0};
        vecs[7]  = '{1'b1, 32'haabbccdd, 1'b0, 1'b0, 32'h0,        1'b1, 32'haabbccdd, 32'h100,      1};
        vecs[8]  = '{1'b1, 32'h11111111, 1'b1, 1'b0, 32'h0,        1'b1, 32'h11111111, 32'h104,      1};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h0,        32'h0,        0};
        vecs[10] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,        1'b1, 32'h22222222, 32'hfffffffc, 1};
        vecs[11] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b1, 32'h22222222, 32'hfffffffc, 2};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h33333333, 32'h0,        1};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        0};
    end

    // ---------------- test sequence and final report ----------------
    initial begin
        idle();
        @(posedge clk_in);
        #1;

        // Reset state
        cycle(1'b1, 1'b1, 32'hdeadbeef, 1'b1, 1'b1, 32'h40);
        idle();
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_deq_instr", deq_instr, 32'h0);
        chk("rst_deq_pc", deq_pc, 32'h0);

        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, vecs[i].iv, vecs[i].ins, vecs[i].dr, vecs[i].fl, vecs[i].rpc);
            idle();
            chk($sformatf("vec%0d_valid", i), 32'(deq_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_instr", i), deq_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc", i), deq_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
        end

        // Fill, then overflow on a full queue
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 32'h0);
        idle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_enq_ready", 32'(enq_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ovf_before", 32'(overflow), 32'd0);
        cycle(1'b0, 1'b1, 32'h00368693, 1'b1, 1'b0, 32'h0);
        idle();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd7);
        chk("ovf_head_pc", deq_pc, 32'd4);
        cycle(1'b0, 1'b1, 32'h00368693, 1'b0, 1'b0, 32'h0);
        idle();
        chk("refill_tail_count", 32'(count), 32'd8);
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            chk($sformatf("pop%0d_pc", i), deq_pc, 32'(4 * i));
            chk($sformatf("pop%0d_instr", i), deq_instr, 32'h1000 + 32'(i));
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        idle();
        chk("last_pc", deq_pc, 32'd32);
        chk("last_instr", deq_instr, 32'h00368693);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_ovf_sticky", 32'(overflow), 32'd1);

        // Wrap-around: steady enqueue+dequeue at count 3
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            idle();
            chk($sformatf("wrap%0d_pc", k), deq_pc, 32'd36 + 32'(4 * k));
            cycle(1'b0, 1'b1, 32'h2003 + 32'(k), 1'b1, 1'b0, 32'h0);
        end
        idle();
        chk("wrap_count", 32'(count), 32'd3);
        chk("wrap_head_instr", deq_instr, 32'h2014);

        // Flush at count 5 with a concurrent enqueue
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0, 32'h0);
        idle();
        chk("pre_flush_count", 32'(count), 32'd5);
        cycle(1'b0, 1'b1, 32'h4444, 1'b1, 1'b1, 32'h100);
        idle();
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ovf_kept", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b1, 32'h5555, 1'b0, 1'b0, 32'h0);
        idle();
        chk("redirect_pc", deq_pc, 32'h100);

`ifdef IQ_BYPASS_EN
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();
        iq_valid = 1'b1; deq_ready = 1'b1; instruction = 32'h00470713;
        #1;
        chk("byp_valid", 32'(deq_valid), 32'd1);
        chk("byp_pc", deq_pc, 32'h0);
        chk("byp_instr", deq_instr, 32'h00470713);
        cycle(1'b0, 1'b1, 32'h00470713, 1'b1, 1'b0, 32'h0);
        idle();
        chk("byp_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b1, 32'h6666, 1'b0, 1'b0, 32'h0);
        idle();
        chk("byp_next_pc", deq_pc, 32'h4);
`endif

        // Randomized run against the reference model, in phases of varying pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 200; c++) begin
                logic r, iv, dr, fl;
                r  = ($urandom_range(0, 149) == 0);
                fl = ($urandom_range(0, 24) == 0);
                iv = ($urandom_range(0, 99) < (ph == 1 ? 85 : 55));
                dr = ($urandom_range(0, 99) < (ph == 2 ? 85 : 50));
                cycle(r, iv, $urandom, dr, fl, {$urandom_range(0, 32'h3fff_ffff), 2'b00});
            end
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- In-order instruction buffer between the fetch/stimulus source and the decode/dispatch stage of the superscalar core.
- Upstream pushes raw 32-bit RISC-V words with a one-cycle valid pulse. Each accepted word is tagged with a sequential PC.
- Downstream pops entries with a ready/valid handshake, the reader side of the iq_valid/instruction interface.
- Also supports a pipeline flush with PC redirect, for branch mispredicts.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PC_RESET, 32'h0000_0000, PC assigned to the first instruction after reset.

Ports:
- clk_in  input  1  system clock; every register updates on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- iq_valid  input  1  enqueue strobe; one instruction per cycle while high.
- instruction  input  32  instruction word to enqueue.
- enq_ready  output  1  high when the queue can accept an enqueue (!full); advisory only.
- deq_valid  output  1  head entry available.
- deq_ready  input  1  consumer accepts the head this cycle.
- deq_instr  output  32  head instruction word.
- deq_pc  output  32  PC tag of the head entry.
- flush  input  1  discard all entries.
- redirect_pc  input  32  next PC tag to use after a flush.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: an enqueue was dropped because the queue was full.

Behaviour:
- Reset (rst_in high at a clock edge):
  - read/write pointers and count go to 0; next_pc goes to PC_RESET.
  - overflow clears; deq_valid=0, empty=1, full=0, enq_ready=1.
  - deq_instr and deq_pc read as 0.
  - Reset overrides flush, enqueue and dequeue in the same cycle.
- Storage:
  - circular array of {pc[31:0], instr[31:0]}.
  - pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Enqueue:
  - fires when iq_valid && !full && !flush.
  - writes {next_pc, instruction} at the write pointer.
  - write pointer increments; next_pc += 4 (32-bit, wraps modulo 2^32).
- Dequeue:
  - fires when deq_valid && deq_ready && !flush; read pointer increments.
- deq_valid = !empty. deq_instr and deq_pc are driven combinationally from the head entry; they read as 0 when the queue is empty.
- Latency: an instruction enqueued at edge N is visible at deq_* after edge N, i.e. one cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full:
  - iq_valid while full drops the word; next_pc does not advance; overflow sets and stays set until reset.
  - A same-cycle dequeue does not rescue it: enq_ready deliberately excludes deq_ready to avoid a combinational path.
- Empty: deq_ready is ignored.
- Flush:
  - pointers and count go to 0; next_pc loads redirect_pc.
  - any same-cycle enqueue and dequeue are discarded.
  - overflow is unaffected.
- Flush with iq_valid in the same cycle: the word is dropped and overflow is not set.
- No state machine beyond the pointer/count registers. count is maintained explicitly, not derived from the pointers.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - when empty && iq_valid && !flush, deq_valid=1 in the same cycle.
  - deq_instr=instruction, deq_pc=next_pc.
  - if deq_ready is also high, the word is consumed and not stored: pointers and count are unchanged, next_pc += 4.
  - if deq_ready is low, the word is stored normally.
- Undefined: deq_valid is purely !empty, giving a strict one-cycle minimum latency.

Decomposition:
- Shared package iq_pkg:
  - typedef iq_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam IQ_PC_STEP = 4
  - IQ_DEFAULT_DEPTH = 8
- One sub-module, iq_ring_buffer: the parameterised storage array with read/write pointers and count.
- instruction_queue itself adds the PC tagging, flush, overflow and bypass logic.

Test Plan:
- Reset, then iq_valid=1 with instruction=32'h00158593 for one cycle, deq_ready=0 -> next cycle: deq_valid=1, deq_instr=32'h00158593, deq_pc=0, count=1.
- Enqueue 32'h00158593 then 32'h00260613, then deq_ready=1 for two cycles -> pops in order with pc 0 then 4; empty=1 afterwards.
- Fill 8 entries, then iq_valid with 32'h00368693 -> full=1, enq_ready=0, word dropped, overflow=1, count stays 8.
  - Next 8 pops return pc 0..28.
- Wrap-around: 20 cycles of simultaneous enqueue/dequeue at count=3 -> order preserved, count stays 3, pc sequence continuous.
- flush=1 with redirect_pc=32'h0000_0100 while count=5 and iq_valid=1 -> next cycle: empty=1, overflow unchanged.
  - The next enqueue gets pc 32'h100.
- IQ_BYPASS_EN defined, queue empty, iq_valid=1 and deq_ready=1 with 32'h00470713 -> deq_valid=1 the same cycle with pc=next_pc; count remains 0.
